// File: rtl/lr_sequencer_if.sv
// Unified-buffer read bus and leaky-relu lane bus between lr_sequencer (master)
// and the buffer / leaky-relu pair (slave).
interface lr_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic                     ub_rd_en;
    logic [ADDR_W-1:0]        ub_rd_addr;
    logic signed [DATA_W-1:0] ub_rd_data_1;
    logic signed [DATA_W-1:0] ub_rd_data_2;
    logic signed [DATA_W-1:0] lr_data_1_out;
    logic signed [DATA_W-1:0] lr_data_2_out;
    logic                     lr_valid_1_out;
    logic                     lr_valid_2_out;
    logic signed [DATA_W-1:0] lr_leak_factor_out;
    logic                     lr_valid_1_in;
    logic                     lr_valid_2_in;

    modport master (
        output ub_rd_en, ub_rd_addr,
        output lr_data_1_out, lr_data_2_out, lr_valid_1_out, lr_valid_2_out,
        output lr_leak_factor_out,
        input  ub_rd_data_1, ub_rd_data_2,
        input  lr_valid_1_in, lr_valid_2_in
    );

    modport slave (
        input  ub_rd_en, ub_rd_addr,
        input  lr_data_1_out, lr_data_2_out, lr_valid_1_out, lr_valid_2_out,
        input  lr_leak_factor_out,
        output ub_rd_data_1, ub_rd_data_2,
        output lr_valid_1_in, lr_valid_2_in
    );
endinterface

// File: rtl/lr_sequencer.sv
// Streams a job of buffer rows into a two-lane leaky-relu pair and waits for all results.
// Optional macro LR_SEQ_SKEW_EN delays lane 2 by one cycle (systolic skew).
module lr_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        row_count,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic signed [DATA_W-1:0] leak_factor_in,
    output logic                     busy,
    output logic                     done,
    lr_sequencer_if.master           bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:0]        rows_q, rows_d;
    logic [ADDR_W-1:0]        rd_left_q, rd_left_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic signed [DATA_W-1:0] leak_q, leak_d;
    logic [CNT_W-1:0]         cnt1_q, cnt1_d;
    logic [CNT_W-1:0]         cnt2_q, cnt2_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     v1_q, v2_q;
    logic signed [DATA_W-1:0] d1_q, d2_q;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        rd_left_d = rd_left_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        leak_d    = leak_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;

        if (state_q == ST_READ || state_q == ST_DRAIN) begin
            if (bus.lr_valid_1_in) cnt1_d = cnt1_q + CNT_W'(1);
            if (bus.lr_valid_2_in) cnt2_d = cnt2_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d = row_count;
                    leak_d = leak_factor_in;
                    cnt1_d = '0;
                    cnt2_d = '0;
                    if (row_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr;
                        rd_left_d = row_count - ADDR_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (rd_left_q != '0) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - ADDR_W'(1);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Next-count compare so final returns arriving this cycle are included
                if (cnt1_d == CNT_W'(rows_q) && cnt2_d == CNT_W'(rows_q)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            rd_left_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            leak_q    <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            rd_left_q <= rd_left_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            leak_q    <= leak_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef LR_SEQ_SKEW_EN
    logic                     skew_v_q;
    logic signed [DATA_W-1:0] skew_d_q;
`endif

    // Lane datapath: data captured only with its valid, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            d1_q     <= '0;
            v2_q     <= 1'b0;
            d2_q     <= '0;
`ifdef LR_SEQ_SKEW_EN
            skew_v_q <= 1'b0;
            skew_d_q <= '0;
`endif
        end else begin
            v1_q <= rd_en_q;
            if (rd_en_q) d1_q <= bus.ub_rd_data_1;
`ifdef LR_SEQ_SKEW_EN
            skew_v_q <= rd_en_q;
            if (rd_en_q) skew_d_q <= bus.ub_rd_data_2;
            v2_q <= skew_v_q;
            if (skew_v_q) d2_q <= skew_d_q;
`else
            v2_q <= rd_en_q;
            if (rd_en_q) d2_q <= bus.ub_rd_data_2;
`endif
        end
    end

    assign bus.ub_rd_en           = rd_en_q;
    assign bus.ub_rd_addr         = rd_addr_q;
    assign bus.lr_data_1_out      = d1_q;
    assign bus.lr_data_2_out      = d2_q;
    assign bus.lr_valid_1_out     = v1_q;
    assign bus.lr_valid_2_out     = v2_q;
    assign bus.lr_leak_factor_out = leak_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
endmodule

// File: tb/tb_lr_sequencer.sv
// Directed bench for lr_sequencer: buffer returns 0x1000+addr / 0x2000+addr,
// leaky-relu pair returns each lane valid one cycle later.
module tb_lr_sequencer;
`ifdef LR_SEQ_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         row_count;
    logic [7:0]         base_addr;
    logic signed [15:0] leak_factor_in;
    logic               busy;
    logic               done;
    logic               ret1 = 1'b0;
    logic               ret2 = 1'b0;
    int                 n_checks = 0;
    int                 n_fail = 0;

    lr_sequencer_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    lr_sequencer #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .row_count      (row_count),
        .base_addr      (base_addr),
        .leak_factor_in (leak_factor_in),
        .busy           (busy),
        .done           (done),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    assign bus.ub_rd_data_1  = bus.ub_rd_en ? 16'h1000 + 16'(bus.ub_rd_addr) : 16'hDEAD;
    assign bus.ub_rd_data_2  = bus.ub_rd_en ? 16'h2000 + 16'(bus.ub_rd_addr) : 16'hBEEF;
    assign bus.lr_valid_1_in = ret1;
    assign bus.lr_valid_2_in = ret2;

    always @(posedge clk) begin
        ret1 <= bus.lr_valid_1_out;
        ret2 <= bus.lr_valid_2_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic string tag(input string n, input int k, input string f);
        return $sformatf("%s@c%0d.%s", n, k, f);
    endfunction

    task automatic check_zero_outputs(input string n);
        check({n, ".rd_en"}, 32'(bus.ub_rd_en), 32'd0);
        check({n, ".addr"},  32'(bus.ub_rd_addr), 32'd0);
        check({n, ".v1"},    32'(bus.lr_valid_1_out), 32'd0);
        check({n, ".v2"},    32'(bus.lr_valid_2_out), 32'd0);
        check({n, ".d1"},    32'($unsigned(bus.lr_data_1_out)), 32'd0);
        check({n, ".d2"},    32'($unsigned(bus.lr_data_2_out)), 32'd0);
        check({n, ".leak"},  32'($unsigned(bus.lr_leak_factor_out)), 32'd0);
        check({n, ".busy"},  32'(busy), 32'd0);
        check({n, ".done"},  32'(done), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; start is sampled at the next rising edge (cycle 0).
    // inj_cyc: cycle in which a second start (5 rows @0x80, inj_leak) is pulsed, -1 for none.
    task automatic run_job(input int rc, input int base, input int leak,
                           input int inj_cyc, input int inj_leak, input string name);
        int         done_cyc;
        int         last;
        logic [7:0] a;
        done_cyc = (rc == 0) ? 1 : rc + 3 + SKEW;
        last     = done_cyc + 2;
        start          = 1'b1;
        row_count      = 8'(rc);
        base_addr      = 8'(base);
        leak_factor_in = 16'(leak);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            start = 1'b0;
            check(tag(name, k, "rd_en"), 32'(bus.ub_rd_en), 32'(k <= rc));
            if (k <= rc) begin
                a = 8'(base + k - 1);
                check(tag(name, k, "addr"), 32'(bus.ub_rd_addr), 32'(a));
            end
            check(tag(name, k, "v1"), 32'(bus.lr_valid_1_out), 32'(k >= 2 && k <= rc + 1));
            if (k >= 2 && k <= rc + 1) begin
                a = 8'(base + k - 2);
                check(tag(name, k, "d1"), 32'($unsigned(bus.lr_data_1_out)), 32'(16'h1000 + 16'(a)));
            end
            check(tag(name, k, "v2"), 32'(bus.lr_valid_2_out),
                  32'(k >= 2 + SKEW && k <= rc + 1 + SKEW));
            if (k >= 2 + SKEW && k <= rc + 1 + SKEW) begin
                a = 8'(base + k - 2 - SKEW);
                check(tag(name, k, "d2"), 32'($unsigned(bus.lr_data_2_out)), 32'(16'h2000 + 16'(a)));
            end
            check(tag(name, k, "busy"), 32'(busy), 32'(rc != 0 && k < done_cyc));
            check(tag(name, k, "done"), 32'(done), 32'(k == done_cyc));
            check(tag(name, k, "leak"), 32'($unsigned(bus.lr_leak_factor_out)), 32'(16'(leak)));
            if (k == inj_cyc) begin
                start          = 1'b1;
                row_count      = 8'd5;
                base_addr      = 8'h80;
                leak_factor_in = 16'(inj_leak);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        start          = 1'b0;
        row_count      = '0;
        base_addr      = '0;
        leak_factor_in = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("por");
        rst = 1'b1;

        run_job(3, 'h10, 'h0033, -1, 0, "basic");
        run_job(0, 'h55, 'h0011, -1, 0, "zero");
        run_job(4, 'hFE, 'h0021, -1, 0, "wrap");
        run_job(3, 'h40, 'h0033, 2, 'h0100, "midstart");
        run_job(2, 'h20, 'h0044, 5 + SKEW, 'h0100, "donestart");
        run_job(1, 'h7F, 'h0012, -1, 0, "single");

        // Abort a 5-row job in DRAIN with an asynchronous reset
        start          = 1'b1;
        row_count      = 8'd5;
        base_addr      = 8'h50;
        leak_factor_in = 16'h0055;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst.busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1 check_zero_outputs("midrst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(tag("midrst_hold", k, "done"), 32'(done), 32'd0);
            check(tag("midrst_hold", k, "v2"), 32'(bus.lr_valid_2_out), 32'd0);
        end
        rst = 1'b1;
        run_job(2, 'h30, 'h0066, -1, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
